mem_fill_check: RTL and testbench
=================================

# mem_fill_check

Write-then-verify sequencer that sits directly upstream of `reg_mem`, driving its address, write-data and write-enable ports and consuming its read data. On `start` it fills every location with an incrementing pattern, reads every location back, compares each word against the expected value, and reports a pass flag, a mismatch count and the first failing address. It replaces the hand-written fill/readback loops in benches and gives the memory a self-test used at power-up.

## Interface
- `DATA_WIDTH`, 8, word width; must match `reg_mem`.
- `ADDR_BITS`, 5, address width; N = 2^ADDR_BITS locations swept.
- `READ_LAT`, 1, cycles from `mem_addr` to valid `mem_dout`; legal values 0, 1, 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `base_data`  in  DATA_WIDTH  pattern seed; captured on accepted `start`.
- `addr_offset`  in  ADDR_BITS  first address; captured on accepted `start`.
- `mem_addr`  out  ADDR_BITS  to `reg_mem` addr.
- `mem_din`  out  DATA_WIDTH  to `reg_mem` data_in.
- `mem_wen`  out  1  to `reg_mem` wen.
- `mem_dout`  in  DATA_WIDTH  from `reg_mem` data_out.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  1 when the last sweep had zero mismatches.
- `err_count`  out  ADDR_BITS+1  mismatches in last sweep.
- `first_err_addr`  out  ADDR_BITS  address of the first mismatch; 0 if none.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: `mem_wen`=0. `start`=1 → capture `base_data`, `addr_offset`; clear `err_count`, `first_err_addr`, `pass`; go to WRITE with index i=0.
- WRITE: for i = 0..N-1, one per cycle: `mem_addr` = (addr_offset + i) mod N, `mem_din` = (base_data + i) mod 2^DATA_WIDTH, `mem_wen`=1. After i=N-1 → READ with i=0.
- READ: for i = 0..N-1: same `mem_addr` sequence, `mem_wen`=0, `mem_din` holds its last value. Expected word (base_data + i) and its address enter a READ_LAT-deep pipeline. After i=N-1 → DRAIN (skipped if READ_LAT=0, going straight to DONE).
- DRAIN: READ_LAT cycles; compares still complete, no new addresses issued (`mem_addr` holds).
- Compare: when a pipeline entry matures, `mem_dout` != expected → `err_count`+1. If this is the first mismatch, latch its address into `first_err_addr`. `err_count` cannot overflow, since its maximum is N.
- DONE: `done`=1 for one cycle, `pass` = (err_count==0), → IDLE. `pass`, `err_count` and `first_err_addr` hold until the next accepted `start`.
- Arithmetic: address and data increments wrap modulo their widths, so no carry is kept. For example, offset 30 with N=32 gives addresses 30, 31, 0, 1, ...
- `start` while not IDLE is ignored. `start` held high in the DONE cycle is not accepted. `start` held high through IDLE re-launches the sweep.
- `rst` in any state → IDLE next edge and all outputs return to their reset values. A sweep interrupted by reset gives no `done` and no results.

## Timing
- Reset values: `mem_addr`=0, `mem_din`=0, `mem_wen`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_addr`=0.
- All outputs are registered, with no combinational path from `start` or `mem_dout` to any output.
- `start` sampled at edge E0. The first write (i=0) is presented during cycle E0..E1 and committed by `reg_mem` at edge E1.
- Writes occupy N cycles and reads the next N cycles. `mem_wen` is 1 for exactly N consecutive cycles.
- READ_LAT=0 means `mem_dout` is combinational from `mem_addr` and is sampled in the same cycle. READ_LAT=k means it is sampled k cycles after the address cycle.
- `done` is high in cycle 2N + READ_LAT + 1 counted from E0. With defaults (N=32, READ_LAT=1) that is cycle 66. `busy` is high for cycles 1..2N+READ_LAT.
- The first read of a location always follows its write by N cycles, so there is no read-during-write hazard.

## Test plan
- Default params with an ideal `reg_mem` model: base_data=0x0A, addr_offset=2, pulse start → writes 0x0A..0x29 to addresses 2..31,0,1; `done` at cycle 66; `pass`=1, `err_count`=0, `first_err_addr`=0.
- Data wrap: base_data=0xF0, offset=0 → address 16 is written with 0x00 and address 31 with 0x0F; `pass`=1.
- Fault injection: the memory model forces bit 3 of address 5 to 1; base_data=0, offset=0 → `err_count`=1, `first_err_addr`=5, `pass`=0. Stuck bit 0 on all words → `err_count`=16, `first_err_addr`=0.
- Latency sweep: READ_LAT=0, 1 and 2, each with a matching memory model → `pass`=1 and `done` at cycles 65, 66 and 67 respectively. READ_LAT=2 against a 1-cycle model → `pass`=0.
- Control: `start` pulsed at cycles 10 and 40 of a running sweep → ignored, and exactly one `done` occurs. `rst` asserted at cycle 20 → `mem_wen`=0 and `busy`=0 after the next edge, no `done`. A new start then completes normally.
- Back-to-back: `start` held high → sweeps repeat, with IDLE lasting exactly one cycle between `done` and the next sweep's `busy`. Results update at each `done`.

Source files
------------

// File: rtl/mem_fill_check_if.sv
// ---------------------------------------------------------------------------
// mem_fill_check_if
// Memory-side bus between mem_fill_check and a reg_mem style memory.
//   mem_addr  : word address (sequencer -> memory)
//   mem_din   : write data   (sequencer -> memory)
//   mem_wen   : write enable (sequencer -> memory)
//   mem_dout  : read data    (memory -> sequencer)
// Modports: master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
interface mem_fill_check_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5
);
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport master (output mem_addr, output mem_din, output mem_wen, input mem_dout);
    modport slave  (input mem_addr, input mem_din, input mem_wen, output mem_dout);
endinterface

// File: rtl/mem_fill_check.sv
// ---------------------------------------------------------------------------
// mem_fill_check
// Write-then-verify sequencer for a reg_mem. On an accepted start it writes
// base_data+i to address addr_offset+i for every location, reads every
// location back in the same order, and compares each word after READ_LAT
// cycles. Reports pass / mismatch count / first failing address.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : launch a sweep (only looked at in IDLE)
//   base_data       : pattern seed, captured on accepted start
//   addr_offset     : first address, captured on accepted start
//   mem             : memory bus (master modport)
//   busy            : sweep in progress (cycle after start .. last compare)
//   done            : one-cycle pulse at sweep end
//   pass            : last sweep had zero mismatches
//   err_count       : mismatches in last sweep
//   first_err_addr  : address of first mismatch, 0 if none
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module mem_fill_check #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base_data,
    input  logic [ADDR_BITS-1:0]  addr_offset,
    mem_fill_check_if.master      mem,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_BITS:0]    err_count,
    output logic [ADDR_BITS-1:0]  first_err_addr
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    localparam logic [ADDR_BITS-1:0] IDX_LAST   = '1;
    // idx doubles as the drain counter; it only needs to reach READ_LAT-1
    localparam logic [ADDR_BITS-1:0] DRAIN_LAST =
        (READ_LAT > 0) ? ADDR_BITS'(READ_LAT - 1) : '0;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  idx_q, idx_d, idx_inc;
    logic [DATA_WIDTH-1:0] base_q, base_d;
    logic [ADDR_BITS-1:0]  off_q, off_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  wen_q, wen_d;
    logic                  busy_d, done_d, pass_d;
    logic [ADDR_BITS:0]    err_d;
    logic [ADDR_BITS-1:0]  first_d;

    // read issue stage: what the current READ cycle expects back
    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] rd_exp;
    logic [ADDR_BITS-1:0]  rd_addr;

    // compare stage: entry maturing this cycle
    logic                  cmp_vld;
    logic [DATA_WIDTH-1:0] cmp_exp;
    logic [ADDR_BITS-1:0]  cmp_addr;
    logic                  cmp_bad;

    assign mem.mem_addr = addr_q;
    assign mem.mem_din  = din_q;
    assign mem.mem_wen  = wen_q;

    assign idx_inc = idx_q + 1'b1;
    assign rd_vld  = (state_q == READ);
    assign rd_exp  = base_q + DATA_WIDTH'(idx_q);
    assign rd_addr = addr_q;

    // -----------------------------------------------------------------------
    // Expected-word pipeline, READ_LAT deep. With zero latency the memory
    // answers in the address cycle, so the issue stage is compared directly.
    // -----------------------------------------------------------------------
    generate
        if (READ_LAT == 0) begin : g_nopipe
            assign cmp_vld  = rd_vld;
            assign cmp_exp  = rd_exp;
            assign cmp_addr = rd_addr;
        end else begin : g_pipe
            logic [READ_LAT:1]     vld_pipe;
            logic [DATA_WIDTH-1:0] exp_pipe  [1:READ_LAT];
            logic [ADDR_BITS-1:0]  addr_pipe [1:READ_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe[1] <= rd_vld;
                    for (int s = 2; s <= READ_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
                end
            end

            always_ff @(posedge clk) begin
                exp_pipe[1]  <= rd_exp;
                addr_pipe[1] <= rd_addr;
                for (int s = 2; s <= READ_LAT; s++) begin
                    exp_pipe[s]  <= exp_pipe[s-1];
                    addr_pipe[s] <= addr_pipe[s-1];
                end
            end

            assign cmp_vld  = vld_pipe[READ_LAT];
            assign cmp_exp  = exp_pipe[READ_LAT];
            assign cmp_addr = addr_pipe[READ_LAT];
        end
    endgenerate

    assign cmp_bad = cmp_vld && (mem.mem_dout != cmp_exp);

    // -----------------------------------------------------------------------
    // Next-state / next-output logic. Outputs are computed one cycle ahead
    // and registered, so every bus value is presented for a full cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        off_d   = off_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wen_d   = 1'b0;
        pass_d  = pass;
        err_d   = err_count;
        first_d = first_err_addr;

        if (cmp_bad) begin
            err_d = err_count + 1'b1;
            if (err_count == '0) first_d = cmp_addr;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    idx_d   = '0;
                    base_d  = base_data;
                    off_d   = addr_offset;
                    addr_d  = addr_offset;
                    din_d   = base_data;
                    wen_d   = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    first_d = '0;
                end
            end
            WRITE: begin
                if (idx_q == IDX_LAST) begin
                    state_d = READ;
                    idx_d   = '0;
                    addr_d  = off_q;
                end else begin
                    idx_d  = idx_inc;
                    addr_d = off_q + idx_inc;
                    din_d  = base_q + DATA_WIDTH'(idx_inc);
                    wen_d  = 1'b1;
                end
            end
            READ: begin
                if (idx_q == IDX_LAST) begin
                    state_d = (READ_LAT == 0) ? DONE : DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d  = idx_inc;
                    addr_d = off_q + idx_inc;
                end
            end
            DRAIN: begin
                if (idx_q == DRAIN_LAST) state_d = DONE;
                else                     idx_d   = idx_inc;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The final compare lands on the edge into DONE, so pass uses err_d.
        if (state_d == DONE) pass_d = (err_d == '0);

        busy_d = (state_d == WRITE) || (state_d == READ) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            base_q         <= '0;
            off_q          <= '0;
            addr_q         <= '0;
            din_q          <= '0;
            wen_q          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            base_q         <= base_d;
            off_q          <= off_d;
            addr_q         <= addr_d;
            din_q          <= din_d;
            wen_q          <= wen_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            err_count      <= err_d;
            first_err_addr <= first_d;
        end
    end

endmodule

// File: tb/tb_mem_fill_check.sv
// ---------------------------------------------------------------------------
// tb_mem_fill_check
// Three sequencers (READ_LAT = 0, 1, 2), each driving its own behavioural
// memory whose read latency and fault pattern are selectable at run time.
// Directed steps in one initial block; cycle numbers count from the start
// sampling edge (cycle 1 is the first cycle after it).
// ---------------------------------------------------------------------------
module tb_mem_fill_check;
    localparam int DW = 8;
    localparam int AB = 5;
    localparam int N  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]    start_v;
    logic [DW-1:0] base_a  [3];
    logic [AB-1:0] off_a   [3];
    logic [2:0]    busy_v, done_v, pass_v, wen_v;
    logic [AB:0]   err_a   [3];
    logic [AB-1:0] ferr_a  [3];
    logic [AB-1:0] maddr_a [3];
    logic [DW-1:0] mdin_a  [3];

    int lat_a [3];
    int fault_mode;   // 0 none, 1 addr 5 bit 3 stuck-1, 2 bit 0 stuck-1 everywhere

    int n_cmp = 0;
    int n_bad = 0;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            mem_fill_check_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus ();

            mem_fill_check #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .READ_LAT(g)) dut (
                .clk            (clk),
                .rst            (rst),
                .start          (start_v[g]),
                .base_data      (base_a[g]),
                .addr_offset    (off_a[g]),
                .mem            (bus.master),
                .busy           (busy_v[g]),
                .done           (done_v[g]),
                .pass           (pass_v[g]),
                .err_count      (err_a[g]),
                .first_err_addr (ferr_a[g])
            );

            logic [DW-1:0] mem [N];
            logic [DW-1:0] raw, rd1, rd2;

            always @(posedge clk) if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_din;

            always_comb begin
                raw = mem[bus.mem_addr];
                if (fault_mode == 1 && bus.mem_addr == 5) raw[3] = 1'b1;
                else if (fault_mode == 2)                 raw[0] = 1'b1;
            end

            always @(posedge clk) begin
                rd1 <= raw;
                rd2 <= rd1;
            end

            assign bus.mem_dout = (lat_a[g] == 0) ? raw : (lat_a[g] == 1) ? rd1 : rd2;
            assign wen_v[g]     = bus.mem_wen;
            assign maddr_a[g]   = bus.mem_addr;
            assign mdin_a[g]    = bus.mem_din;
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns in cycle 1 of the sweep.
    task automatic launch(input int g, input logic [DW-1:0] b, input logic [AB-1:0] o);
        base_a[g]  = b;
        off_a[g]   = o;
        start_v[g] = 1'b1;
        tick(1);
        start_v[g] = 1'b0;
    endtask

    // Called in cycle 1; returns in the done cycle (or after the budget).
    task automatic wait_done(input int g, output int cyc, output int wen_cnt);
        cyc     = 1;
        wen_cnt = 0;
        while (!done_v[g] && cyc < 300) begin
            if (wen_v[g]) wen_cnt++;
            tick(1);
            cyc++;
        end
    endtask

    initial begin
        int cyc, wc, dcnt, dcyc, d1, b2, d2;

        start_v    = '0;
        fault_mode = 0;
        lat_a      = '{0, 1, 2};
        for (int i = 0; i < 3; i++) begin
            base_a[i] = '0;
            off_a[i]  = '0;
        end

        // reset state
        tick(3);
        check("rst_busy", busy_v[1], 0);
        check("rst_done", done_v[1], 0);
        check("rst_pass", pass_v[1], 0);
        check("rst_err",  err_a[1], 0);
        check("rst_ferr", ferr_a[1], 0);
        check("rst_wen",  wen_v[1], 0);
        check("rst_addr", maddr_a[1], 0);
        check("rst_din",  mdin_a[1], 0);
        rst = 1'b0;
        tick(1);

        // basic fill/verify, offset 2
        launch(1, 8'h0A, 5'd2);
        wait_done(1, cyc, wc);
        check("t1_done_cyc", cyc, 66);
        check("t1_wen_cnt", wc, 32);
        check("t1_pass", pass_v[1], 1);
        check("t1_err", err_a[1], 0);
        check("t1_ferr", ferr_a[1], 0);
        check("t1_mem2", g_dut[1].mem[2], 8'h0A);
        check("t1_mem31", g_dut[1].mem[31], 8'h27);
        check("t1_mem1", g_dut[1].mem[1], 8'h29);
        tick(3);
        check("t1_done_pulse", done_v[1], 0);
        check("t1_pass_hold", pass_v[1], 1);

        // data wrap
        launch(1, 8'hF0, 5'd0);
        wait_done(1, cyc, wc);
        check("t2_mem16", g_dut[1].mem[16], 8'h00);
        check("t2_mem31", g_dut[1].mem[31], 8'h0F);
        check("t2_pass", pass_v[1], 1);
        tick(2);

        // single-bit fault at address 5
        fault_mode = 1;
        launch(1, 8'h00, 5'd0);
        wait_done(1, cyc, wc);
        check("t3_err", err_a[1], 1);
        check("t3_ferr", ferr_a[1], 5);
        check("t3_pass", pass_v[1], 0);
        tick(2);

        // bit 0 stuck high: every even word fails
        fault_mode = 2;
        launch(1, 8'h00, 5'd0);
        wait_done(1, cyc, wc);
        check("t4_err", err_a[1], 16);
        check("t4_ferr", ferr_a[1], 0);
        check("t4_pass", pass_v[1], 0);
        fault_mode = 0;
        tick(2);

        // latency sweep
        launch(0, 8'h33, 5'd7);
        wait_done(0, cyc, wc);
        check("t5_lat0_cyc", cyc, 65);
        check("t5_lat0_pass", pass_v[0], 1);
        tick(2);
        launch(2, 8'h33, 5'd7);
        wait_done(2, cyc, wc);
        check("t5_lat2_cyc", cyc, 67);
        check("t5_lat2_pass", pass_v[2], 1);
        tick(2);
        // READ_LAT=2 sequencer against a 1-cycle memory sees the next word;
        // only the last read matches since the address holds in DRAIN
        lat_a[2] = 1;
        launch(2, 8'h33, 5'd7);
        wait_done(2, cyc, wc);
        check("t5_mislat_pass", pass_v[2], 0);
        check("t5_mislat_err", err_a[2], 31);
        check("t5_mislat_ferr", ferr_a[2], 7);
        lat_a[2] = 2;
        tick(2);

        // start pulses during a sweep are ignored
        launch(1, 8'h55, 5'd3);
        cyc  = 1;
        dcnt = 0;
        dcyc = 0;
        while (cyc <= 100) begin
            if (done_v[1]) begin
                dcnt++;
                if (dcyc == 0) dcyc = cyc;
            end
            start_v[1] = (cyc == 10 || cyc == 40);
            tick(1);
            cyc++;
        end
        start_v[1] = 1'b0;
        check("t6_done_cnt", dcnt, 1);
        check("t6_done_cyc", dcyc, 66);
        check("t6_pass", pass_v[1], 1);

        // reset in the middle of a sweep
        launch(1, 8'h11, 5'd0);
        tick(19);
        rst = 1'b1;
        tick(1);
        check("t7_wen", wen_v[1], 0);
        check("t7_busy", busy_v[1], 0);
        check("t7_addr", maddr_a[1], 0);
        check("t7_pass", pass_v[1], 0);
        rst  = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 80; k++) begin
            if (done_v[1]) dcnt++;
            tick(1);
        end
        check("t7_no_done", dcnt, 0);
        launch(1, 8'h22, 5'd9);
        wait_done(1, cyc, wc);
        check("t7_restart_cyc", cyc, 66);
        check("t7_restart_pass", pass_v[1], 1);
        tick(2);

        // start held high: back-to-back sweeps, results refresh at each done
        fault_mode = 1;
        base_a[1]  = 8'h00;
        off_a[1]   = 5'd0;
        start_v[1] = 1'b1;
        tick(1);
        d1 = 0;
        b2 = 0;
        d2 = 0;
        for (int k = 1; k <= 200 && d2 == 0; k++) begin
            if (done_v[1]) begin
                if (d1 == 0) begin
                    d1 = k;
                    check("t8_first_pass", pass_v[1], 0);
                    check("t8_first_err", err_a[1], 1);
                    fault_mode = 0;
                end else begin
                    d2 = k;
                    check("t8_second_pass", pass_v[1], 1);
                    check("t8_second_err", err_a[1], 0);
                    start_v[1] = 1'b0;
                end
            end
            if (d1 != 0 && b2 == 0 && busy_v[1]) b2 = k;
            tick(1);
        end
        start_v[1] = 1'b0;
        check("t8_d1", d1, 66);
        check("t8_busy_again", b2, 68);
        check("t8_d2", d2, 133);
        tick(3);
        check("t8_stopped", busy_v[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
